capture_buffer: RTL and testbench

Parametrised trace-capture memory for the internal logic analyzer: a circular sample buffer with a programmable pre-trigger depth and a post-trigger fill, followed by an oldest-first streaming readout over a valid/ready handshake. It sits between the trigger/sample front end and the host readout path. It generalises the plain dual-port sample memory by adding capture sequencing, wrap-around addressing, stall-safe readout and an optional output register.

---
 rtl/capture_buffer.sv | 181 ++++++++++++++++++
 tb/tb_capture_buffer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_buffer.sv
// capture_buffer: circular trace-capture memory with pre/post-trigger sequencing and an
// oldest-first valid/ready readout. Define CAPTURE_OUTREG_EN to add a register after the RAM read port.
module capture_buffer #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  arm,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] pretrig_count,
   input  logic                  sample_valid,
   input  logic [DATA_WIDTH-1:0] sample_data,
   input  logic                  trigger,
   output logic                  armed,
   output logic                  triggered,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] trig_addr,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_last
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = {ADDR_WIDTH{1'b1}};
   localparam logic [ADDR_WIDTH:0]   NUM_SAMPLES = {1'b1, {ADDR_WIDTH{1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_PRETRIG, S_WAIT_TRIG, S_POSTTRIG, S_READ} state_t;

   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_waddr, r_fill, r_pre, r_post, r_raddr, r_trig_addr;
   logic [ADDR_WIDTH:0]   r_issued;
   logic                  r_armed, r_triggered, r_done;
   logic [DATA_WIDTH-1:0] r_ram_q;
   logic                  r_ram_vld, r_ram_last;

   logic                  w_capturing, w_wr_en, w_s1_load, w_issue, w_xfer_last;
   logic [ADDR_WIDTH-1:0] w_waddr_inc, w_fill_inc;

   assign w_capturing = (r_state == S_PRETRIG) || (r_state == S_WAIT_TRIG) || (r_state == S_POSTTRIG);
   assign w_wr_en     = w_capturing && sample_valid && !abort;
   assign w_waddr_inc = r_waddr + 1'b1;
   assign w_fill_inc  = r_fill + 1'b1;
   assign w_xfer_last = rd_valid && rd_ready && rd_last;
   assign w_issue     = w_s1_load && (r_state == S_READ) && (r_issued != NUM_SAMPLES);

   assign armed     = r_armed;
   assign triggered = r_triggered;
   assign done      = r_done;
   assign trig_addr = r_trig_addr;

   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_waddr] <= sample_data;
   end

   // pretrig_count is ADDR_WIDTH bits, so it can never exceed DEPTH-1 and needs no clamp
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_waddr     <= '0;
         r_fill      <= '0;
         r_pre       <= '0;
         r_post      <= '0;
         r_raddr     <= '0;
         r_trig_addr <= '0;
         r_issued    <= '0;
         r_armed     <= 1'b0;
         r_triggered <= 1'b0;
         r_done      <= 1'b0;
      end else if (abort) begin
         r_state     <= S_IDLE;
         r_armed     <= 1'b0;
         r_triggered <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         if (w_issue) begin
            r_raddr  <= r_raddr + 1'b1;
            r_issued <= r_issued + 1'b1;
         end
         case (r_state)
            S_IDLE: if (arm) begin
               r_pre   <= pretrig_count;
               r_waddr <= '0;
               r_fill  <= '0;
               r_armed <= 1'b1;
               r_state <= (pretrig_count == '0) ? S_WAIT_TRIG : S_PRETRIG;
            end
            S_PRETRIG: if (sample_valid) begin
               r_waddr <= w_waddr_inc;
               r_fill  <= w_fill_inc;
               if (w_fill_inc == r_pre) r_state <= S_WAIT_TRIG;
            end
            S_WAIT_TRIG: if (sample_valid) begin
               r_waddr <= w_waddr_inc;
               if (trigger) begin
                  r_trig_addr <= r_waddr;
                  r_post      <= LAST_ADDR - r_pre;
                  r_triggered <= 1'b1;
                  if (r_pre == LAST_ADDR) begin
                     r_state  <= S_READ;
                     r_armed  <= 1'b0;
                     r_done   <= 1'b1;
                     r_raddr  <= r_waddr - r_pre;
                     r_issued <= '0;
                  end else begin
                     r_state <= S_POSTTRIG;
                  end
               end
            end
            S_POSTTRIG: if (sample_valid) begin
               r_waddr <= w_waddr_inc;
               r_post  <= r_post - 1'b1;
               if (r_post == {{(ADDR_WIDTH-1){1'b0}}, 1'b1}) begin
                  r_state  <= S_READ;
                  r_armed  <= 1'b0;
                  r_done   <= 1'b1;
                  r_raddr  <= r_trig_addr - r_pre;
                  r_issued <= '0;
               end
            end
            S_READ: if (w_xfer_last) begin
               r_state     <= S_IDLE;
               r_triggered <= 1'b0;
               r_done      <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // RAM read register: refills whenever the downstream slot is free or being consumed
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ram_q    <= '0;
         r_ram_vld  <= 1'b0;
         r_ram_last <= 1'b0;
      end else if (abort) begin
         r_ram_vld  <= 1'b0;
         r_ram_last <= 1'b0;
      end else if (w_s1_load) begin
         r_ram_vld  <= w_issue;
         r_ram_last <= w_issue && (r_issued == {1'b0, LAST_ADDR});
         if (w_issue) r_ram_q <= r_mem[r_raddr];
      end
   end

`ifdef CAPTURE_OUTREG_EN
   logic [DATA_WIDTH-1:0] r_out_q;
   logic                  r_out_vld, r_out_last;
   logic                  w_out_load;

   assign w_out_load = !r_out_vld || rd_ready;
   assign w_s1_load  = !r_ram_vld || w_out_load;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_out_q    <= '0;
         r_out_vld  <= 1'b0;
         r_out_last <= 1'b0;
      end else if (abort) begin
         r_out_vld  <= 1'b0;
         r_out_last <= 1'b0;
      end else if (w_out_load) begin
         r_out_vld  <= r_ram_vld;
         r_out_last <= r_ram_last;
         if (r_ram_vld) r_out_q <= r_ram_q;
      end
   end

   assign rd_valid = r_out_vld;
   assign rd_data  = r_out_q;
   assign rd_last  = r_out_last;
`else
   assign w_s1_load = !r_ram_vld || rd_ready;
   assign rd_valid  = r_ram_vld;
   assign rd_data   = r_ram_q;
   assign rd_last   = r_ram_last;
`endif

endmodule

// File: tb/tb_capture_buffer.sv
// Bench for capture_buffer (DEPTH=16): directed table scenarios, abort/reset sequences and
// randomized captures checked against a sample-history model of the capture rules.
`timescale 1ns/1ps
module tb_capture_buffer;
   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
`ifdef CAPTURE_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          arm = 1'b0, abort = 1'b0, sample_valid = 1'b0, trigger = 1'b0, rd_ready = 1'b0;
   logic [AW-1:0] pretrig_count = '0;
   logic [DW-1:0] sample_data = '0;
   logic          armed, triggered, done, rd_valid, rd_last;
   logic [AW-1:0] trig_addr;
   logic [DW-1:0] rd_data;

   int            n_vec = 0;
   int            n_err = 0;
   logic [DW-1:0] m_store[$];
   int            m_t;
   int            m_pre;

   typedef struct {
      int pre;
      int mode;
      int tval;
      int period;
      int exp_trig;
      int exp_first;
      int exp_last;
   } vec_t;

   always #5 clk = ~clk;

   capture_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset_n(reset_n), .arm(arm), .abort(abort), .pretrig_count(pretrig_count),
      .sample_valid(sample_valid), .sample_data(sample_data), .trigger(trigger),
      .armed(armed), .triggered(triggered), .done(done), .trig_addr(trig_addr),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last)
   );

   task automatic check1(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkn(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bg_drive();
      sample_valid = 1'($urandom % 2);
      sample_data  = 8'($urandom);
      trigger      = 1'($urandom % 2);
   endtask

   // mode 0: ramp, trigger on value tval; mode 1: ramp, trigger always; mode 2: random samples
   task automatic run_capture(input int pre, input int mode, input int tval, output int ok);
      int done_idx, cyc, ramp;
      logic v, tr;
      logic [DW-1:0] d;
      m_store.delete();
      m_t = -1; m_pre = pre; done_idx = -1; ramp = 0; cyc = 0;
      pretrig_count = 4'(pre);
      arm = 1'b1; sample_valid = 1'b1; sample_data = 8'hEE; trigger = 1'b1;
      step();
      arm = 1'b0;
      check1("armed_after_arm", armed, 1'b1);
      check1("done_after_arm", done, 1'b0);
      while (!(done_idx >= 0 && m_store.size() > done_idx) && cyc < 400) begin
         if (mode == 2) begin
            v  = ($urandom % 4) != 0;
            d  = 8'($urandom);
            tr = ($urandom % 6) == 0;
            if (m_store.size() > 48) tr = 1'b1;
         end else begin
            v  = 1'b1;
            d  = 8'(ramp);
            tr = (mode == 1) || (ramp == tval);
            ramp++;
         end
         sample_valid = v; sample_data = d; trigger = tr;
         step();
         cyc++;
         if (v) begin
            if (m_t < 0 && m_store.size() >= pre && tr) begin
               m_t = m_store.size();
               done_idx = m_t + DEPTH - 1 - pre;
            end
            m_store.push_back(d);
         end
         check1("triggered_flag", triggered, m_t >= 0);
         check1("armed_flag", armed, !(done_idx >= 0 && m_store.size() > done_idx));
      end
      sample_valid = 1'b0; trigger = 1'b0;
      ok = (done_idx >= 0 && m_store.size() > done_idx) ? 1 : 0;
      checkn("capture_complete", ok, 1);
      if (ok != 0) begin
         check1("done_at_read", done, 1'b1);
         checkn("trig_addr", 32'(trig_addr), 32'(m_t % DEPTH));
      end
   endtask

   task automatic run_readout(input int period, input int abort_at,
                              output logic [DW-1:0] first, output logic [DW-1:0] last);
      int lat, n, k;
      logic hv, hl, rdy;
      logic [DW-1:0] hd;
      first = '0; last = '0;
      lat = 0;
      while (!rd_valid && lat < 8) begin
         bg_drive();
         step();
         lat++;
      end
      checkn("first_valid_latency", lat, LAT);
      n = 0; k = 0; hv = 1'b0; hl = 1'b0; hd = '0;
      while (n < DEPTH && k < 200) begin
         if (hv) begin
            check1("hold_valid", rd_valid, 1'b1);
            checkn("hold_data", 32'(rd_data), 32'(hd));
            check1("hold_last", rd_last, hl);
         end
         if (n == abort_at) begin
            abort = 1'b1; rd_ready = 1'b0;
            step();
            abort = 1'b0; sample_valid = 1'b0; trigger = 1'b0;
            check1("abort_rd_valid", rd_valid, 1'b0);
            check1("abort_rd_last", rd_last, 1'b0);
            check1("abort_done", done, 1'b0);
            check1("abort_triggered", triggered, 1'b0);
            check1("abort_armed", armed, 1'b0);
            return;
         end
         rdy = (period == 0) ? 1'($urandom % 2) : ((k % period) == 0);
         rd_ready = rdy;
         if (rd_valid && rdy) begin
            checkn("rd_data", 32'(rd_data), 32'(m_store[m_t - m_pre + n]));
            check1("rd_last", rd_last, n == DEPTH - 1);
            if (n == 0) first = rd_data;
            last = rd_data;
            n++;
            hv = 1'b0;
         end else if (rd_valid) begin
            hv = 1'b1; hd = rd_data; hl = rd_last;
         end else begin
            hv = 1'b0;
         end
         bg_drive();
         step();
         k++;
      end
      rd_ready = 1'b0; sample_valid = 1'b0; trigger = 1'b0;
      checkn("handshakes", n, DEPTH);
      check1("post_rd_valid", rd_valid, 1'b0);
      check1("post_done", done, 1'b0);
      check1("post_triggered", triggered, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[5];
      int ok;
      logic [DW-1:0] f, l;
      tbl[0] = '{4,  0, 20, 1, 4,  16, 31};
      tbl[1] = '{0,  0, 0,  1, 0,  0,  15};
      tbl[2] = '{15, 1, 0,  1, 15, 0,  15};
      tbl[3] = '{4,  0, 20, 3, 4,  16, 31};
      tbl[4] = '{7,  0, 40, 2, 8,  33, 48};

      repeat (3) step();
      check1("rst_armed", armed, 1'b0);
      check1("rst_triggered", triggered, 1'b0);
      check1("rst_done", done, 1'b0);
      check1("rst_rd_valid", rd_valid, 1'b0);
      check1("rst_rd_last", rd_last, 1'b0);
      checkn("rst_rd_data", 32'(rd_data), 0);
      checkn("rst_trig_addr", 32'(trig_addr), 0);
      reset_n = 1'b1;
      step();

      pretrig_count = 4'd4; arm = 1'b1; abort = 1'b1;
      step();
      arm = 1'b0; abort = 1'b0;
      check1("arm_abort_armed", armed, 1'b0);
      step();
      check1("arm_abort_stays_idle", armed, 1'b0);

      for (int i = 0; i < 5; i++) begin
         run_capture(tbl[i].pre, tbl[i].mode, tbl[i].tval, ok);
         checkn("tbl_trig_addr", 32'(trig_addr), 32'(tbl[i].exp_trig));
         run_readout(tbl[i].period, -1, f, l);
         checkn("tbl_first", 32'(f), 32'(tbl[i].exp_first));
         checkn("tbl_last", 32'(l), 32'(tbl[i].exp_last));
      end

      run_capture(4, 0, 20, ok);
      run_readout(1, 5, f, l);
      step();
      check1("abort_idle_rd_valid", rd_valid, 1'b0);
      run_capture(2, 0, 10, ok);
      run_readout(1, -1, f, l);
      checkn("rearm_first", 32'(f), 8);
      checkn("rearm_last", 32'(l), 23);

      for (int r = 0; r < 6; r++) begin
         run_capture(int'($urandom % 16), 2, 0, ok);
         run_readout(0, -1, f, l);
      end

      pretrig_count = 4'd4; arm = 1'b1;
      step();
      arm = 1'b0;
      for (int i = 0; i < 9; i++) begin
         sample_valid = 1'b1; sample_data = 8'(i + 100); trigger = (i == 6);
         step();
      end
      sample_valid = 1'b0; trigger = 1'b0;
      check1("pre_reset_armed", armed, 1'b1);
      check1("pre_reset_triggered", triggered, 1'b1);
      checkn("pre_reset_trig_addr", 32'(trig_addr), 6);
      #2 reset_n = 1'b0;
      #1;
      check1("async_rst_armed", armed, 1'b0);
      check1("async_rst_triggered", triggered, 1'b0);
      check1("async_rst_done", done, 1'b0);
      check1("async_rst_rd_valid", rd_valid, 1'b0);
      check1("async_rst_rd_last", rd_last, 1'b0);
      checkn("async_rst_rd_data", 32'(rd_data), 0);
      checkn("async_rst_trig_addr", 32'(trig_addr), 0);
      step();
      reset_n = 1'b1;
      step();
      run_capture(4, 0, 20, ok);
      run_readout(1, -1, f, l);
      checkn("post_reset_first", 32'(f), 16);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
